// File: rtl/adc_spi_rx.sv
// adc_spi_rx: sample timer plus CNV/SCK/SDO sequencer for a 16-bit SPI SAR ADC.
// Each conversion ends with a one-cycle adc_done strobe and a fresh adc_data word
// that is held until the next strobe.
module adc_spi_rx #(
   parameter int unsigned PERIOD      = 1000,
   parameter int unsigned CONV_CYCLES = 100,
   parameter int unsigned SCK_HALF    = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        adc_sdo,
   output logic        adc_cnv,
   output logic        adc_sck,
   output logic [15:0] adc_data,
   output logic        adc_done,
   output logic        busy,
   output logic        overrun
);

   localparam int unsigned PW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam int unsigned PH_MAX = (CONV_CYCLES > SCK_HALF) ? CONV_CYCLES : SCK_HALF;
   localparam int unsigned PHW    = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

   localparam logic [PW-1:0]  PERIOD_LAST = PW'(PERIOD - 1);
   localparam logic [PHW-1:0] CONV_LAST   = PHW'(CONV_CYCLES - 1);
   localparam logic [PHW-1:0] HALF_LAST   = PHW'(SCK_HALF - 1);

   typedef enum logic [1:0] {StIdle, StConv, StShift, StDone} state_e;

   state_e          state_q;
   logic [PW-1:0]   period_q;
   logic [PHW-1:0]  phase_q;   // cycles spent in CONV, or within the current SCK half-period
   logic [4:0]      edge_q;    // SCK toggles issued so far (32 per sample)
   logic [15:0]     shreg_q;
   logic            tick;

   assign tick = enable && (period_q == PERIOD_LAST);

   // Free-running sample timer; held at zero while disabled.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         period_q <= '0;
      end else if (!enable || tick) begin
         period_q <= '0;
      end else begin
         period_q <= period_q + PW'(1);
      end
   end

   // Conversion sequencer with registered ADC pins and status outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= StIdle;
         phase_q  <= '0;
         edge_q   <= '0;
         shreg_q  <= '0;
         adc_cnv  <= 1'b0;
         adc_sck  <= 1'b0;
         adc_data <= '0;
         adc_done <= 1'b0;
         busy     <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         adc_done <= 1'b0;
         // A trigger is only honoured in IDLE; anywhere else it is dropped and flagged.
         if (tick && (state_q != StIdle)) begin
            overrun <= 1'b1;
         end
         case (state_q)
            StIdle: begin
               if (tick) begin
                  state_q <= StConv;
                  adc_cnv <= 1'b1;
                  busy    <= 1'b1;
                  phase_q <= '0;
               end
            end
            StConv: begin
               if (phase_q == CONV_LAST) begin
                  state_q <= StShift;
                  adc_cnv <= 1'b0;
                  phase_q <= '0;
                  edge_q  <= '0;
               end else begin
                  phase_q <= phase_q + PHW'(1);
               end
            end
            StShift: begin
               if (phase_q == HALF_LAST) begin
                  phase_q <= '0;
                  adc_sck <= ~adc_sck;
                  edge_q  <= edge_q + 5'd1;
                  // Sample on the edge that raises SCK; data was launched on the prior fall.
                  if (!adc_sck) begin
                     shreg_q <= {shreg_q[14:0], adc_sdo};
                  end
                  // 32nd toggle returns SCK low: the word is complete.
                  if (edge_q == 5'd31) begin
                     state_q  <= StDone;
                     adc_data <= shreg_q;
                     adc_done <= 1'b1;
                  end
               end else begin
                  phase_q <= phase_q + PHW'(1);
               end
            end
            StDone: begin
               state_q <= StIdle;
               busy    <= 1'b0;
            end
            default: begin
               state_q <= StIdle;
               busy    <= 1'b0;
               adc_cnv <= 1'b0;
               adc_sck <= 1'b0;
            end
         endcase
      end
   end

endmodule
